// File: rtl/multi_port_rd_mem.sv
// Preloadable word memory with NUM_PORTS independent, fully pipelined read channels.
// Out-of-range accesses return zero, never write, and set a sticky error flag.
module multi_port_rd_mem #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 1024,
  parameter int NUM_PORTS  = 3,
  parameter int RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ld_en,
  input  logic [ADDR_W-1:0]             ld_addr,
  input  logic [DATA_W-1:0]             ld_data,
  input  logic [NUM_PORTS-1:0]          rd_en,
  input  logic [NUM_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [NUM_PORTS*DATA_W-1:0]   rd_data,
  output logic [NUM_PORTS-1:0]          rd_valid,
  output logic                          err_oor,
  output logic [31:0]                   rd_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable as the bound.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0]    mem [DEPTH];
  logic                 ld_ok;
  logic [ADDR_W-1:0]    addr_k  [NUM_PORTS];
  logic [NUM_PORTS-1:0] rd_ok;
  logic [DATA_W-1:0]    rd_word [NUM_PORTS];
  logic [31:0]          hits;

  logic [NUM_PORTS-1:0] pipe_v [RD_LATENCY];
  logic [DATA_W-1:0]    pipe_d [RD_LATENCY][NUM_PORTS];

  assign ld_ok = {1'b0, ld_addr} < LIMIT;

  // NOTE: storage has no reset branch; it keeps its contents across rst and maps to plain RAM.
  always_ff @(posedge clk) begin
    if (ld_en && ld_ok) begin
      mem[ld_addr[IDX_W-1:0]] <= ld_data;
    end
  end

  // NOTE: combinational logic uses blocking '=' with a default first, so nothing is held as a latch.
  always_comb begin
    hits = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      addr_k[k]  = rd_addr[k*ADDR_W +: ADDR_W];
      rd_ok[k]   = {1'b0, addr_k[k]} < LIMIT;
      rd_word[k] = rd_ok[k] ? mem[addr_k[k][IDX_W-1:0]] : '0;
      hits       = hits + 32'(rd_en[k] & rd_ok[k]);
    end
  end

  // The read samples mem before this edge's write lands, which gives read-before-write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        pipe_v[s] <= '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
          pipe_d[s][k] <= '0;
        end
      end
      err_oor  <= 1'b0;
      rd_count <= '0;
    end else begin
      pipe_v[0] <= rd_en;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (rd_en[k]) begin
          pipe_d[0][k] <= rd_word[k];
        end
      end
      for (int s = 1; s < RD_LATENCY; s++) begin
        pipe_v[s] <= pipe_v[s-1];
        for (int k = 0; k < NUM_PORTS; k++) begin
          if (pipe_v[s-1][k]) begin
            pipe_d[s][k] <= pipe_d[s-1][k];
          end
        end
      end
      if ((ld_en && !ld_ok) || (|(rd_en & ~rd_ok))) begin
        err_oor <= 1'b1;
      end
      rd_count <= rd_count + hits;
    end
  end

  assign rd_valid = pipe_v[RD_LATENCY-1];

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_out
    assign rd_data[k*DATA_W +: DATA_W] = pipe_d[RD_LATENCY-1][k];
  end

endmodule
